intra4_mode_select: RTL and testbench

Scores a sequence of candidate 4x4 intra predictions against the source block and keeps the best one. Sits directly downstream of the 4x4 intra predictor bank (LD4 and sibling modes): each predictor's 16-pixel output block is streamed in with its mode index, and this block produces the winning mode, its SAD and its prediction for the residual/transform stage. Pipelined: one candidate accepted per cycle, result valid a fixed latency after the last candidate.

---
 rtl/intra4_mode_select.sv | 140 ++++++++++++++
 tb/tb_intra4_mode_select.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/intra4_mode_select.sv
// Scores a stream of candidate 4x4 intra predictions against a latched source block
// and keeps the lowest-SAD candidate (earliest wins on ties).
module intra4_mode_select #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned BLOCK_SIZE = 4,
    parameter int unsigned MODE_NUM   = 10,
    parameter int unsigned SAD_WIDTH  = BIT_WIDTH + 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] src,
    input  logic                                   pred_valid,
    output logic                                   pred_ready,
    input  logic [3:0]                             pred_mode,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred,
    output logic                                   busy,
    output logic                                   done,
    output logic [3:0]                             best_mode,
    output logic [SAD_WIDTH-1:0]                   best_sad,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] best_pred
);

    localparam int unsigned PIX_NUM = BLOCK_SIZE * BLOCK_SIZE;
    localparam int unsigned BLK_W   = BIT_WIDTH * PIX_NUM;
    localparam int unsigned CNT_W   = $clog2(MODE_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MODE_NUM - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]     count_q;
    logic [BLK_W-1:0]     src_q;
    logic                 accept;
    logic                 drain_done;
    logic                 done_q;
    logic [3:0]           best_mode_q;
    logic [SAD_WIDTH-1:0] best_sad_q;
    logic [BLK_W-1:0]     best_pred_q;

    // Pipeline: s0 = registered candidate, s1 = abs diffs, s2 = SAD
    logic                 v0_q, v1_q, v2_q;
    logic [3:0]           mode0_q, mode1_q, mode2_q;
    logic [BLK_W-1:0]     pred0_q, pred1_q, pred2_q;
    logic [BIT_WIDTH-1:0] ad_d [PIX_NUM];
    logic [BIT_WIDTH-1:0] ad1_q [PIX_NUM];
    logic [SAD_WIDTH-1:0] sad_d;
    logic [SAD_WIDTH-1:0] sad2_q;

    assign pred_ready = (state_q == StCollect) && (count_q <= CNT_LAST);
    assign accept     = pred_valid && pred_ready;
    // Last candidate sits in s2 with nothing behind it: it compares on this edge
    assign drain_done = (state_q == StDrain) && v2_q && !v1_q && !v0_q;

    assign busy      = (state_q != StIdle) || done_q;
    assign done      = done_q;
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;
    assign best_pred = best_pred_q;

    always_comb begin
        for (int i = 0; i < int'(PIX_NUM); i++) begin
            if (src_q[BIT_WIDTH*i +: BIT_WIDTH] > pred0_q[BIT_WIDTH*i +: BIT_WIDTH]) begin
                ad_d[i] = src_q[BIT_WIDTH*i +: BIT_WIDTH] - pred0_q[BIT_WIDTH*i +: BIT_WIDTH];
            end else begin
                ad_d[i] = pred0_q[BIT_WIDTH*i +: BIT_WIDTH] - src_q[BIT_WIDTH*i +: BIT_WIDTH];
            end
        end
    end

    always_comb begin
        sad_d = '0;
        for (int i = 0; i < int'(PIX_NUM); i++) begin
            sad_d = sad_d + SAD_WIDTH'(ad1_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StCollect;
            StCollect: if (accept && (count_q == CNT_LAST)) state_d = StDrain;
            StDrain:   if (drain_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            src_q       <= '0;
            done_q      <= 1'b0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            best_pred_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= drain_done;
            v0_q    <= accept;
            v1_q    <= v0_q;
            v2_q    <= v1_q;
            if ((state_q == StIdle) && start) begin
                src_q      <= src;
                count_q    <= '0;
                best_sad_q <= '1;
            end
            if (accept) begin
                count_q <= count_q + 1'b1;
            end
            if (v2_q && (sad2_q < best_sad_q)) begin
                best_mode_q <= mode2_q;
                best_sad_q  <= sad2_q;
                best_pred_q <= pred2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mode0_q <= pred_mode;
            pred0_q <= pred;
        end
        if (v0_q) begin
            mode1_q <= mode0_q;
            pred1_q <= pred0_q;
            ad1_q   <= ad_d;
        end
        if (v1_q) begin
            mode2_q <= mode1_q;
            pred2_q <= pred1_q;
            sad2_q  <= sad_d;
        end
    end

endmodule

// File: tb/tb_intra4_mode_select.sv
// Directed self-checking bench for intra4_mode_select with hand-computed winners.
module tb_intra4_mode_select;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] src;
    logic         pred_valid;
    logic         pred_ready;
    logic [3:0]   pred_mode;
    logic [127:0] pred;
    logic         busy;
    logic         done;
    logic [3:0]   best_mode;
    logic [11:0]  best_sad;
    logic [127:0] best_pred;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] cand_pred [10];
    logic [3:0]   cand_mode [10];

    intra4_mode_select dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src        (src),
        .pred_valid (pred_valid),
        .pred_ready (pred_ready),
        .pred_mode  (pred_mode),
        .pred       (pred),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .best_pred  (best_pred)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] fill(input logic [7:0] v);
        fill = {16{v}};
    endfunction

    // Runs one block; inputs are driven and outputs sampled on the falling edge
    task automatic run_block(input string name, input logic [127:0] s, input bit gaps,
                             input bit poke, input logic [127:0] poke_src,
                             input logic [3:0] exp_mode, input logic [11:0] exp_sad,
                             input logic [127:0] exp_pred);
        int acc = 0;
        int guard = 0;
        int lat = 0;
        bit got = 0;
        bit tog = 1;
        bit poked = 0;
        bit valid;
        bit ready_seen;
        @(negedge clk);
        start = 1'b1;
        src = s;
        pred_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_start"}, 128'(busy), 128'(1'b1));
        check({name, "_sad_init"}, 128'(best_sad), 128'(12'hFFF));
        while (acc < 10 && guard < 100) begin
            guard++;
            valid = gaps ? tog : 1'b1;
            tog = ~tog;
            pred_valid = valid;
            pred = cand_pred[acc];
            pred_mode = cand_mode[acc];
            if (poke && !poked && acc == 4) begin
                start = 1'b1;
                src = poke_src;
                poked = 1;
            end else begin
                start = 1'b0;
            end
            ready_seen = pred_ready;
            @(posedge clk);
            if (valid && ready_seen) acc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_accepts"}, 128'(acc), 128'(10));
        // Extra candidate that would win with SAD 0 if it were wrongly accepted
        pred_valid = 1'b1;
        pred = s;
        pred_mode = 4'hF;
        check({name, "_ready_after_last"}, 128'(pred_ready), 128'(1'b0));
        for (int n = 1; n <= 8 && !got; n++) begin
            @(posedge clk);
            @(negedge clk);
            pred_valid = 1'b0;
            if (done) begin
                got = 1;
                lat = n;
            end
        end
        check({name, "_done_latency"}, 128'(lat), 128'(3));
        check({name, "_busy_at_done"}, 128'(busy), 128'(1'b1));
        check({name, "_best_mode"}, 128'(best_mode), 128'(exp_mode));
        check({name, "_best_sad"}, 128'(best_sad), 128'(exp_sad));
        check({name, "_best_pred"}, best_pred, exp_pred);
        @(negedge clk);
        check({name, "_done_pulse"}, 128'(done), 128'(1'b0));
        check({name, "_busy_after"}, 128'(busy), 128'(1'b0));
        check({name, "_sad_hold"}, 128'(best_sad), 128'(exp_sad));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, 128'(pred_ready), 128'(1'b0));
        check({name, "_busy"}, 128'(busy), 128'(1'b0));
        check({name, "_done"}, 128'(done), 128'(1'b0));
        check({name, "_mode"}, 128'(best_mode), 128'(4'h0));
        check({name, "_sad"}, 128'(best_sad), 128'(12'h0));
        check({name, "_pred"}, best_pred, 128'h0);
    endtask

    initial begin
        logic [127:0] blk;
        bit saw_done;
        rst = 1'b1;
        start = 1'b0;
        src = '0;
        pred_valid = 1'b0;
        pred_mode = '0;
        pred = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int k = 0; k < 10; k++) cand_mode[k] = 4'(k);

        // All equal: tie keeps the first candidate
        for (int k = 0; k < 10; k++) cand_pred[k] = fill(8'h80);
        run_block("tie_all", fill(8'h80), 0, 0, '0, 4'd0, 12'd0, fill(8'h80));

        // Mode 6 clearly best
        for (int k = 0; k < 10; k++) cand_pred[k] = (k == 6) ? fill(8'h01) : fill(8'hFF);
        run_block("mode6", '0, 0, 0, '0, 4'd6, 12'd16, fill(8'h01));

        // Maximum SAD 4080 must not saturate or wrap
        for (int k = 0; k < 10; k++) cand_pred[k] = fill(8'hFF);
        run_block("max_sad", '0, 0, 0, '0, 4'd0, 12'd4080, fill(8'hFF));

        // SAD 20 on modes 3 and 7 with different layouts; 3 must win
        for (int k = 0; k < 10; k++) begin
            blk = (k == 3 || k == 7) ? fill(8'h01) : fill(8'h02);
            if (k == 3) blk[7:0] = 8'h05;
            if (k == 7) blk[127:120] = 8'h05;
            cand_pred[k] = blk;
        end
        blk = fill(8'h01);
        blk[7:0] = 8'h05;
        run_block("tie_3_7", '0, 0, 0, '0, 4'd3, 12'd20, blk);

        // Gapped valid; last candidate is the winner
        for (int k = 0; k < 10; k++) cand_pred[k] = fill(8'(8'h10 + 2 * (10 - k)));
        run_block("gaps", fill(8'h10), 1, 0, '0, 4'd9, 12'd32, fill(8'h12));

        // start during COLLECT with a new src must be ignored
        for (int k = 0; k < 10; k++) cand_pred[k] = fill(8'(8'h30 + 3 * k));
        run_block("poke", fill(8'h40), 0, 1, fill(8'h33), 4'd5, 12'd16, fill(8'h3F));

        // Reset after five accepts
        for (int k = 0; k < 10; k++) cand_pred[k] = (k == 6) ? fill(8'h01) : fill(8'hFF);
        @(negedge clk);
        start = 1'b1;
        src = '0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pred_valid = 1'b1;
            pred = cand_pred[k];
            pred_mode = cand_mode[k];
            @(negedge clk);
        end
        pred_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("midrst_no_done", 128'(saw_done), 128'(1'b0));
        run_block("after_rst", '0, 0, 0, '0, 4'd6, 12'd16, fill(8'h01));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
